// File: rtl/frame_dma_pkg.sv
// Shared definitions for the Farbborg frame-copy engine:
// register offsets, CTRL bit positions and the FSM state type.
package frame_dma_pkg;

    localparam logic [1:0] REG_SRC   = 2'd0;
    localparam logic [1:0] REG_DST   = 2'd1;
    localparam logic [1:0] REG_COUNT = 2'd2;
    localparam logic [1:0] REG_CTRL  = 2'd3;

    localparam int unsigned CTRL_START  = 0;
    localparam int unsigned CTRL_BUSY   = 1;
    localparam int unsigned CTRL_DONE   = 2;
    localparam int unsigned CTRL_IRQ_EN = 3;
    localparam int unsigned CTRL_ABORT  = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_FIN
    } dma_state_e;

endpackage

// File: rtl/frame_dma_regs.sv
// Wishbone slave register file for the frame-copy engine: SRC/DST/COUNT/CTRL,
// registered single-cycle ack, START/ABORT strobes and the level interrupt.
module frame_dma_regs
    import frame_dma_pkg::*;
#(
    parameter int unsigned FB_ENTRIES = 2048
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [1:0]                    reg_adr,
    input  logic [31:0]                   s_dat_i,
    input  logic                          s_cyc_i,
    input  logic                          s_stb_i,
    input  logic                          s_we_i,
    output logic [31:0]                   s_dat_o,
    output logic                          s_ack_o,
    input  logic                          busy,
    input  logic                          done_set,
    output logic                          start,
    output logic                          abort,
    output logic [31:0]                   src,
    output logic [31:0]                   dst,
    output logic [$clog2(FB_ENTRIES):0]   count,
    output logic                          irq_o
);

    localparam int unsigned CW     = $clog2(FB_ENTRIES) + 1;
    localparam logic [31:0] FB_MAX = 32'(FB_ENTRIES);

    logic          req;
    logic          wr;
    logic [29:0]   src_q;
    logic          done;
    logic          irq_en;
    logic [CW-1:0] cnt_clamp;
    logic [31:0]   rdata;

    assign req   = s_cyc_i & s_stb_i & ~s_ack_o;
    assign wr    = req & s_we_i;
    assign start = wr && (reg_adr == REG_CTRL) && s_dat_i[CTRL_START];
    assign abort = wr && (reg_adr == REG_CTRL) && s_dat_i[CTRL_ABORT];
    assign src   = {src_q, 2'b00};

    always_comb begin
        if (s_dat_i > FB_MAX) cnt_clamp = FB_MAX[CW-1:0];
        else                  cnt_clamp = s_dat_i[CW-1:0];
    end

    always_comb begin
        rdata = '0;
        case (reg_adr)
            REG_SRC:   rdata = {src_q, 2'b00};
            REG_DST:   rdata = dst;
            REG_COUNT: rdata[CW-1:0] = count;
            default: begin
                rdata[CTRL_BUSY]   = busy;
                rdata[CTRL_DONE]   = done;
                rdata[CTRL_IRQ_EN] = irq_en;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_ack_o <= 1'b0;
            s_dat_o <= '0;
            src_q   <= '0;
            dst     <= '0;
            count   <= '0;
            done    <= 1'b0;
            irq_en  <= 1'b0;
            irq_o   <= 1'b0;
        end else begin
            s_ack_o <= req;
            irq_o   <= done & irq_en;
            if (req && !s_we_i) s_dat_o <= rdata;
            if (wr && !busy) begin
                case (reg_adr)
                    REG_SRC:   src_q <= s_dat_i[31:2];
                    REG_DST:   dst   <= s_dat_i;
                    REG_COUNT: count <= {cnt_clamp[CW-1:2], 2'b00};
                    default: ;
                endcase
            end
            if (wr && (reg_adr == REG_CTRL)) begin
                irq_en <= s_dat_i[CTRL_IRQ_EN];
                if (s_dat_i[CTRL_DONE]) done <= 1'b0;
            end
            // a completion on the same edge as a clear wins
            if (done_set) done <= 1'b1;
        end
    end

endmodule

// File: rtl/wb_frame_dma.sv
// Frame-copy engine: reads packed 32-bit words over the Wishbone master port and
// writes each byte (MSB first) as one entry of the Farbborg PWM frame window.
module wb_frame_dma
    import frame_dma_pkg::*;
#(
    parameter int unsigned FB_ENTRIES = 2048
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] s_adr_i,
    input  logic [31:0] s_dat_i,
    output logic [31:0] s_dat_o,
    input  logic [3:0]  s_sel_i,
    input  logic        s_cyc_i,
    input  logic        s_stb_i,
    input  logic        s_we_i,
    output logic        s_ack_o,
    output logic [31:0] m_adr_o,
    input  logic [31:0] m_dat_i,
    output logic [31:0] m_dat_o,
    output logic [3:0]  m_sel_o,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    output logic        m_we_o,
    input  logic        m_ack_i,
    output logic        irq_o
);

    localparam int unsigned CW = $clog2(FB_ENTRIES) + 1;

    logic          start, abort, busy, done_set, stop;
    logic [31:0]   cfg_src, cfg_dst;
    logic [CW-1:0] cfg_count;
    logic          unused_bits;

    dma_state_e    state, state_n;
    logic          cyc, cyc_n;
    logic          abort_pend, abort_pend_n;
    logic [31:0]   src_ptr, src_n, dst_ptr, dst_n, wbuf, wbuf_n;
    logic [CW-1:0] remain, remain_n;
    logic [1:0]    idx, idx_n;
    logic [7:0]    wr_byte;

    assign unused_bits = ^{s_sel_i, s_adr_i[31:4], s_adr_i[1:0]};

    frame_dma_regs #(
        .FB_ENTRIES(FB_ENTRIES)
    ) u_regs (
        .clk      (clk),
        .reset    (reset),
        .reg_adr  (s_adr_i[3:2]),
        .s_dat_i  (s_dat_i),
        .s_cyc_i  (s_cyc_i),
        .s_stb_i  (s_stb_i),
        .s_we_i   (s_we_i),
        .s_dat_o  (s_dat_o),
        .s_ack_o  (s_ack_o),
        .busy     (busy),
        .done_set (done_set),
        .start    (start),
        .abort    (abort),
        .src      (cfg_src),
        .dst      (cfg_dst),
        .count    (cfg_count),
        .irq_o    (irq_o)
    );

    assign busy     = (state != ST_IDLE);
    assign done_set = (state == ST_FIN);
    assign stop     = abort_pend | abort;

    // cyc low inside RD/WR is the mandatory idle cycle between transfers
    always_comb begin
        state_n      = state;
        cyc_n        = cyc;
        abort_pend_n = abort_pend;
        src_n        = src_ptr;
        dst_n        = dst_ptr;
        wbuf_n       = wbuf;
        remain_n     = remain;
        idx_n        = idx;
        case (state)
            ST_IDLE: begin
                abort_pend_n = 1'b0;
                if (start) begin
                    src_n    = cfg_src;
                    dst_n    = cfg_dst;
                    remain_n = cfg_count;
                    state_n  = (cfg_count[CW-1:2] != '0) ? ST_RD : ST_FIN;
                end
            end
            ST_RD, ST_WR: begin
                if (abort) abort_pend_n = 1'b1;
                if (!cyc) begin
                    if (stop) state_n = ST_IDLE;
                    else      cyc_n   = 1'b1;
                end else if (m_ack_i) begin
                    cyc_n = 1'b0;
                    if (state == ST_RD) begin
                        wbuf_n  = m_dat_i;
                        src_n   = src_ptr + 32'd4;
                        idx_n   = 2'd0;
                        state_n = ST_WR;
                    end else begin
                        dst_n    = dst_ptr + 32'd4;
                        remain_n = remain - CW'(1);
                        if (idx == 2'd3) state_n = (remain == CW'(1)) ? ST_FIN : ST_RD;
                        else             idx_n   = idx + 2'd1;
                    end
                    if (stop) state_n = ST_IDLE;
                end
            end
            ST_FIN:  state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            cyc        <= 1'b0;
            abort_pend <= 1'b0;
            src_ptr    <= '0;
            dst_ptr    <= '0;
            wbuf       <= '0;
            remain     <= '0;
            idx        <= '0;
        end else begin
            state      <= state_n;
            cyc        <= cyc_n;
            abort_pend <= abort_pend_n;
            src_ptr    <= src_n;
            dst_ptr    <= dst_n;
            wbuf       <= wbuf_n;
            remain     <= remain_n;
            idx        <= idx_n;
        end
    end

    always_comb begin
        case (idx)
            2'd0:    wr_byte = wbuf[31:24];
            2'd1:    wr_byte = wbuf[23:16];
            2'd2:    wr_byte = wbuf[15:8];
            default: wr_byte = wbuf[7:0];
        endcase
    end

    assign m_cyc_o = cyc;
    assign m_stb_o = cyc;
    assign m_we_o  = cyc & (state == ST_WR);
    assign m_sel_o = 4'hF;
    assign m_adr_o = (state == ST_WR) ? dst_ptr : src_ptr;
    assign m_dat_o = {24'h0, wr_byte};

endmodule

// File: tb/tb_wb_frame_dma.sv
// Randomized bench for wb_frame_dma: a bus-slave memory model records every master
// transfer and each run is compared against a list derived from SRC/DST/COUNT.
module tb_wb_frame_dma;

    localparam int unsigned FB = 2048;

    logic        clk, reset;
    logic [31:0] s_adr_i, s_dat_i, s_dat_o;
    logic [3:0]  s_sel_i;
    logic        s_cyc_i, s_stb_i, s_we_i, s_ack_o;
    logic [31:0] m_adr_o, m_dat_i, m_dat_o;
    logic [3:0]  m_sel_o;
    logic        m_cyc_o, m_stb_o, m_we_o, m_ack_i, irq_o;

    wb_frame_dma #(.FB_ENTRIES(FB)) dut (
        .clk(clk), .reset(reset),
        .s_adr_i(s_adr_i), .s_dat_i(s_dat_i), .s_dat_o(s_dat_o), .s_sel_i(s_sel_i),
        .s_cyc_i(s_cyc_i), .s_stb_i(s_stb_i), .s_we_i(s_we_i), .s_ack_o(s_ack_o),
        .m_adr_o(m_adr_o), .m_dat_i(m_dat_i), .m_dat_o(m_dat_o), .m_sel_o(m_sel_o),
        .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_ack_i(m_ack_i),
        .irq_o(irq_o)
    );

    int n_chk = 0;
    int n_bad = 0;

    int cycle = 0, lat = 0, wcnt = 0;
    int rd_cnt = 0, cyc_starts = 0, proto_bad = 0;
    int irq_edge = -1, last_wr_edge = -1, s_ack_edge = 0, start_edge = 0;
    logic        prev_cyc = 1'b0, prev_we = 1'b0, irq_prev = 1'b0;
    logic [31:0] p_adr = '0, p_dat = '0;
    logic [31:0] wr_adr_q[$], wr_dat_q[$], rd_adr_q[$];
    logic [31:0] mem [logic [31:0]];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    // Master-side bus slave: memory reads, write capture, protocol observation
    initial begin
        m_ack_i = 1'b0;
        m_dat_i = '0;
        forever begin
            @(posedge clk);
            cycle++;
            #1;
            if (!reset) begin
                m_ack_i  = 1'b0;
                wcnt     = 0;
                prev_cyc = 1'b0;
            end else begin
                if (m_ack_i) begin
                    m_ack_i = 1'b0;
                    if (m_cyc_o) proto_bad++;
                end else if (m_cyc_o) begin
                    if (!prev_cyc) cyc_starts++;
                    if (prev_cyc && (m_adr_o !== p_adr || m_we_o !== prev_we || m_dat_o !== p_dat))
                        proto_bad++;
                    if (m_sel_o !== 4'hF || m_stb_o !== 1'b1) proto_bad++;
                    if (wcnt < lat) wcnt++;
                    else begin
                        wcnt    = 0;
                        m_ack_i = 1'b1;
                        if (m_we_o) begin
                            wr_adr_q.push_back(m_adr_o);
                            wr_dat_q.push_back(m_dat_o);
                            last_wr_edge = cycle + 1;
                        end else begin
                            rd_cnt++;
                            rd_adr_q.push_back(m_adr_o);
                            m_dat_i = mem.exists(m_adr_o) ? mem[m_adr_o] : 32'hDEADBEEF;
                        end
                    end
                end
                prev_cyc = m_cyc_o;
                prev_we  = m_we_o;
                p_adr    = m_adr_o;
                p_dat    = m_dat_o;
                if (irq_o && !irq_prev && irq_edge < 0) irq_edge = cycle;
                irq_prev = irq_o;
            end
        end
    end

    task automatic wb_xfer(input logic we, input logic [1:0] r, input logic [31:0] wd,
                           output logic [31:0] rd);
        logic ok;
        @(posedge clk);
        #1;
        s_adr_i = ($urandom & 32'hFFFF_FFF3) | {28'h0, r, 2'b00};
        s_dat_i = wd;
        s_sel_i = 4'($urandom);
        s_we_i  = we;
        s_cyc_i = 1'b1;
        s_stb_i = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (s_ack_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("s_ack_tmo", {31'b0, s_ack_o}, 32'd1);
        rd = s_dat_o;
        s_ack_edge = cycle;
        s_cyc_i = 1'b0;
        s_stb_i = 1'b0;
        s_we_i  = 1'b0;
    endtask

    task automatic wb_write(input logic [1:0] r, input logic [31:0] wd);
        logic [31:0] dummy;
        wb_xfer(1'b1, r, wd, dummy);
    endtask

    task automatic wb_read(input logic [1:0] r, output logic [31:0] rd);
        wb_xfer(1'b0, r, 32'h0, rd);
    endtask

    function automatic int unsigned ref_len(input logic [31:0] cnt);
        int unsigned n;
        n = (cnt > FB) ? FB : int'(cnt);
        return n & ~32'd3;
    endfunction

    task automatic prep_mem(input logic [31:0] src, input logic [31:0] cnt);
        for (int unsigned k = 0; k < ref_len(cnt) / 4; k++)
            mem[(src & ~32'd3) + 32'(4 * k)] = $urandom;
    endtask

    task automatic cfg_and_start(input logic [31:0] src, input logic [31:0] dst,
                                 input logic [31:0] cnt, input logic ien);
        wb_write(2'd0, src);
        wb_write(2'd1, dst);
        wb_write(2'd2, cnt);
        wb_write(2'd3, {28'h0, ien, 3'b100});
        rd_adr_q.delete();
        wr_adr_q.delete();
        wr_dat_q.delete();
        rd_cnt = 0;
        cyc_starts = 0;
        proto_bad = 0;
        irq_edge = -1;
        wb_write(2'd3, {28'h0, ien, 3'b001});
        start_edge = s_ack_edge;
    endtask

    task automatic wait_idle(input int budget);
        logic [31:0] c;
        int t_end;
        t_end = cycle + budget;
        c = 32'h2;
        while (c[1] && cycle < t_end) wb_read(2'd3, c);
        if (c[1]) chk("idle_tmo", {31'b0, c[1]}, 32'd0);
    endtask

    task automatic check_xfer(input logic [31:0] src, input logic [31:0] dst,
                              input logic [31:0] cnt, input logic ien);
        int unsigned n;
        int werr, rerr, ref_e;
        logic [31:0] w, c;
        n = ref_len(cnt);
        werr = 0;
        rerr = 0;
        chk("rd_cnt", 32'(rd_cnt), 32'(n / 4));
        chk("wr_cnt", 32'(wr_adr_q.size()), 32'(n));
        for (int unsigned e = 0; e < n && e < wr_adr_q.size(); e++) begin
            w = mem[(src & ~32'd3) + 32'(4 * (e / 4))];
            if (wr_adr_q[e] !== dst + 32'(4 * e)) werr++;
            if (wr_dat_q[e] !== ((w >> (8 * (3 - (e % 4)))) & 32'hFF)) werr++;
        end
        for (int unsigned k = 0; k < rd_adr_q.size(); k++)
            if (rd_adr_q[k] !== (src & ~32'd3) + 32'(4 * k)) rerr++;
        chk("wr_errs", 32'(werr), 32'd0);
        chk("rd_errs", 32'(rerr), 32'd0);
        chk("proto", 32'(proto_bad), 32'd0);
        wb_read(2'd3, c);
        chk("ctrl_done_busy", {30'b0, c[2:1]}, 32'd2);
        if (ien) begin
            ref_e = (n != 0) ? last_wr_edge : start_edge;
            chk("irq_lat", 32'(irq_edge - ref_e), 32'd2);
        end else begin
            chk("irq_off", {31'b0, irq_o}, 32'd0);
        end
    endtask

    initial begin
        logic [31:0] rv, src, dst, cnt;
        logic ien;
        int cs;
        reset = 1'b0;
        s_adr_i = '0; s_dat_i = '0; s_sel_i = '0;
        s_cyc_i = 1'b0; s_stb_i = 1'b0; s_we_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_cyc", {31'b0, m_cyc_o}, 32'd0);
        chk("rst_m_stb", {31'b0, m_stb_o}, 32'd0);
        chk("rst_m_we", {31'b0, m_we_o}, 32'd0);
        chk("rst_m_adr", m_adr_o, 32'd0);
        chk("rst_m_dat", m_dat_o, 32'd0);
        chk("rst_m_sel", {28'b0, m_sel_o}, 32'hF);
        chk("rst_irq", {31'b0, irq_o}, 32'd0);
        chk("rst_s_ack", {31'b0, s_ack_o}, 32'd0);
        reset = 1'b1;
        for (int r = 0; r < 4; r++) begin
            wb_read(2'(r), rv);
            chk("rst_reg", rv, 32'd0);
        end

        wb_write(2'd0, 32'h0000_0103);
        wb_read(2'd0, rv);
        chk("src_lowbits", rv, 32'h100);
        wb_write(2'd2, 32'd5000);
        wb_read(2'd2, rv);
        chk("count_clamp", rv, 32'd2048);
        wb_write(2'd2, 32'd7);
        wb_read(2'd2, rv);
        chk("count_round", rv, 32'd4);

        lat = 0;
        mem[32'h100] = 32'h1122_3344;
        cfg_and_start(32'h100, 32'hF000_0000, 32'd4, 1'b1);
        wait_idle(500);
        check_xfer(32'h100, 32'hF000_0000, 32'd4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("t1_adr", (i < wr_adr_q.size()) ? wr_adr_q[i] : 32'hFFFF_FFFF, 32'hF000_0000 + 32'(4 * i));
            chk("t1_dat", (i < wr_dat_q.size()) ? wr_dat_q[i] : 32'hFFFF_FFFF, 32'h11 * 32'(i + 1));
        end
        chk("t1_irq", {31'b0, irq_o}, 32'd1);

        lat = 1;
        src = $urandom; dst = $urandom & ~32'd3;
        prep_mem(src, 32'd2048);
        cfg_and_start(src, dst, 32'd2048, 1'b1);
        wait_idle(20000);
        check_xfer(src, dst, 32'd2048, 1'b1);
        chk("dst_end", (wr_adr_q.size() > 0) ? wr_adr_q[$] + 32'd4 : 32'h0, dst + 32'h2000);

        lat = 0;
        cnt = 32'd0;
        for (int z = 0; z < 2; z++) begin
            cfg_and_start(32'h40, 32'h80, cnt, 1'b1);
            wait_idle(200);
            check_xfer(32'h40, 32'h80, cnt, 1'b1);
            chk("zero_cycles", 32'(cyc_starts), 32'd0);
            cnt = 32'd3;
        end

        lat = 2;
        src = $urandom; dst = $urandom;
        prep_mem(src, 32'd16);
        cfg_and_start(src, dst, 32'd16, 1'b0);
        wb_write(2'd0, src ^ 32'h0000_1000);
        wb_write(2'd3, 32'h1);
        wait_idle(2000);
        check_xfer(src, dst, 32'd16, 1'b0);
        wb_read(2'd0, rv);
        chk("busy_src_kept", rv, src & ~32'd3);

        lat = 5;
        src = $urandom; dst = $urandom;
        prep_mem(src, 32'd64);
        cfg_and_start(src, dst, 32'd64, 1'b1);
        cs = 0;
        for (int i = 0; i < 200 && cs == 0; i++) begin
            @(posedge clk);
            #1;
            if (m_cyc_o && m_we_o) cs = 1;
        end
        chk("abort_wstb_seen", 32'(cs), 32'd1);
        wb_write(2'd3, 32'h18);
        wait_idle(500);
        cs = cyc_starts;
        repeat (30) @(posedge clk);
        #1;
        chk("abort_quiet", 32'(cyc_starts - cs), 32'd0);
        chk("abort_rd", 32'(rd_cnt), 32'd1);
        chk("abort_wr", 32'(wr_adr_q.size()), 32'd1);
        chk("abort_wdat", (wr_dat_q.size() > 0) ? wr_dat_q[0] : 32'hFFFF_FFFF,
            32'(mem[src & ~32'd3][31:24]));
        wb_read(2'd3, rv);
        chk("abort_ctrl", rv & 32'h6, 32'd0);
        chk("abort_irq", {31'b0, irq_o}, 32'd0);

        lat = 4;
        src = $urandom; dst = $urandom;
        prep_mem(src, 32'd16);
        cfg_and_start(src, dst, 32'd16, 1'b1);
        cs = 0;
        for (int i = 0; i < 200 && cs == 0; i++) begin
            @(posedge clk);
            #1;
            if (m_cyc_o && !m_we_o) cs = 1;
        end
        chk("rst_rstb_seen", 32'(cs), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_async_cyc", {31'b0, m_cyc_o}, 32'd0);
        chk("rst_async_stb", {31'b0, m_stb_o}, 32'd0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        for (int r = 0; r < 4; r++) begin
            wb_read(2'(r), rv);
            chk("rst_mid_reg", rv, 32'd0);
        end
        lat = 1;
        prep_mem(src, 32'd8);
        cfg_and_start(src, dst, 32'd8, 1'b1);
        wait_idle(1000);
        check_xfer(src, dst, 32'd8, 1'b1);

        for (int it = 0; it < 8; it++) begin
            src = $urandom;
            dst = $urandom;
            cnt = $urandom_range(0, 40);
            lat = $urandom_range(0, 3);
            ien = 1'($urandom_range(0, 1));
            prep_mem(src, cnt);
            cfg_and_start(src, dst, cnt, ien);
            wait_idle(2000);
            check_xfer(src, dst, cnt, ien);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
